// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Groups the execute-stage memory request, the data-bus handshake and the
// register writeback/exception outputs of mem_access_ctrl.
//   master : the controller's view (requests/bus responses in, bus/wb out)
//   slave  : the surrounding pipeline + memory view (mirror of master)
// Signals:
//   iRead/iWrite/iAddr/iData/iOpType/iRdAddr   execute-stage memory op
//   oReady/oStall                              accept / pipeline hold
//   oBusReq/oBusWe/oBusAddr/oBusWData/oBusBe   bus request side
//   iBusAck/iBusRData/iBusErr                  bus response side
//   oRegDv/oRegAddr/oRegData                   load writeback
//   oExcValid/oExcCode                         exception pulse
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int cXLEN       = 32,
  parameter int cRegSelBitW = 5
);
  logic                   iRead;
  logic                   iWrite;
  logic [cXLEN-1:0]       iAddr;
  logic [cXLEN-1:0]       iData;
  logic [2:0]             iOpType;
  logic [cRegSelBitW-1:0] iRdAddr;
  logic                   oReady;
  logic                   oStall;
  logic                   oBusReq;
  logic                   oBusWe;
  logic [cXLEN-1:0]       oBusAddr;
  logic [cXLEN-1:0]       oBusWData;
  logic [3:0]             oBusBe;
  logic                   iBusAck;
  logic [cXLEN-1:0]       iBusRData;
  logic                   iBusErr;
  logic                   oRegDv;
  logic [cRegSelBitW-1:0] oRegAddr;
  logic [cXLEN-1:0]       oRegData;
  logic                   oExcValid;
  logic [1:0]             oExcCode;

  modport master (
    input  iRead, iWrite, iAddr, iData, iOpType, iRdAddr,
    input  iBusAck, iBusRData, iBusErr,
    output oReady, oStall, oBusReq, oBusWe, oBusAddr, oBusWData, oBusBe,
    output oRegDv, oRegAddr, oRegData, oExcValid, oExcCode
  );

  modport slave (
    output iRead, iWrite, iAddr, iData, iOpType, iRdAddr,
    output iBusAck, iBusRData, iBusErr,
    input  oReady, oStall, oBusReq, oBusWe, oBusAddr, oBusWData, oBusBe,
    input  oRegDv, oRegAddr, oRegData, oExcValid, oExcCode
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Takes one load/store from the execute stage, runs it over a req/ack data
// bus, aligns store lanes, extracts/extends load data and returns it as a
// register writeback. Decode errors, bus errors and bus timeouts become a
// one-cycle exception pulse. The pipeline is stalled whenever not idle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  mem_access_ctrl_if.master (request, bus, writeback, exception)
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int cXLEN       = 32,
  parameter int cRegSelBitW = 5,
  parameter int cTimeoutCyc = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.master bus
);

  localparam int CW = $clog2(cTimeoutCyc + 1);
  // Last BUS cycle count before a missing ack turns into a timeout fault
  localparam logic [CW-1:0] TMO_LAST = CW'(cTimeoutCyc - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_WB   = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Replicate store data so every lane carries the addressed bytes
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] d);
    logic [31:0] w;
    case (op[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Byte enables for the access size at the given byte offset
  function automatic logic [3:0] lane_be(input logic [2:0] op, input logic [1:0] off);
    logic [3:0] be;
    case (op[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Shift the addressed bytes down and sign/zero extend
  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] r;
    logic [31:0] v;
    r = rdata >> {off, 3'b000};
    case (op)
      3'b000:  v = {{24{r[7]}}, r[7:0]};
      3'b001:  v = {{16{r[15]}}, r[15:0]};
      3'b100:  v = {24'h000000, r[7:0]};
      3'b101:  v = {16'h0000, r[15:0]};
      default: v = r;
    endcase
    return v;
  endfunction

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [1:0]             code_nx_s;
  logic                   illegal_s;
  logic                   misaligned_s;
  logic                   accept_s;
  logic [CW-1:0]          cnt_r;
  logic                   we_r;
  logic [2:0]             op_r;
  logic [1:0]             off_r;
  logic [cRegSelBitW-1:0] rd_r;
  logic [cXLEN-1:0]       bus_addr_r;
  logic [cXLEN-1:0]       bus_wdata_r;
  logic [3:0]             bus_be_r;
  logic                   ready_r;
  logic                   stall_r;
  logic                   req_r;
  logic                   reg_dv_r;
  logic [cRegSelBitW-1:0] reg_addr_r;
  logic [cXLEN-1:0]       reg_data_r;
  logic                   exc_valid_r;
  logic [1:0]             exc_code_r;

  assign accept_s = (state_r == ST_IDLE) && (bus.iRead || bus.iWrite);

  // Decode the incoming op: illegal opType and misalignment (stores win over loads when both set)
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    case (bus.iOpType)
      3'b000: begin
        illegal_s    = 1'b0;
        misaligned_s = 1'b0;
      end
      3'b001: misaligned_s = bus.iAddr[0];
      3'b010: misaligned_s = (bus.iAddr[1:0] != 2'b00);
      3'b100: illegal_s = bus.iWrite;
      3'b101: begin
        illegal_s    = bus.iWrite;
        misaligned_s = bus.iAddr[0];
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Next-state logic; an ack is only looked at while in BUS, where oBusReq is high
  always_comb begin
    state_nx_s = state_r;
    code_nx_s  = 2'b00;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (illegal_s) begin
            state_nx_s = ST_ERR;
            code_nx_s  = 2'b10;
          end else if (misaligned_s) begin
            state_nx_s = ST_ERR;
            code_nx_s  = 2'b01;
          end else begin
            state_nx_s = ST_BUS;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus.iBusAck) begin
          if (bus.iBusErr) begin
            state_nx_s = ST_ERR;
            code_nx_s  = 2'b11;
          end else if (we_r) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_WB;
          end
        end else if (cnt_r == TMO_LAST) begin
          state_nx_s = ST_ERR;
          code_nx_s  = 2'b11;
        end else begin
          state_nx_s = ST_BUS;
        end
      end
      ST_WB:   state_nx_s = ST_IDLE;
      ST_ERR:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register, request capture, timeout counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      we_r        <= 1'b0;
      op_r        <= 3'b000;
      off_r       <= 2'b00;
      rd_r        <= '0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
      bus_be_r    <= 4'b0000;
      ready_r     <= 1'b1;
      stall_r     <= 1'b0;
      req_r       <= 1'b0;
      reg_dv_r    <= 1'b0;
      reg_addr_r  <= '0;
      reg_data_r  <= '0;
      exc_valid_r <= 1'b0;
      exc_code_r  <= 2'b00;
    end else begin
      state_r <= state_nx_s;
      ready_r <= (state_nx_s == ST_IDLE);
      stall_r <= (state_nx_s != ST_IDLE);
      req_r   <= (state_nx_s == ST_BUS);

      // Request fields are frozen at accept so the bus side stays stable until ack
      if (accept_s) begin
        we_r        <= bus.iWrite;
        op_r        <= bus.iOpType;
        off_r       <= bus.iAddr[1:0];
        rd_r        <= bus.iRdAddr;
        bus_addr_r  <= {bus.iAddr[cXLEN-1:2], 2'b00};
        bus_wdata_r <= store_data(bus.iOpType, bus.iData);
        bus_be_r    <= lane_be(bus.iOpType, bus.iAddr[1:0]);
      end

      // Counts BUS cycles; zero on every entry to BUS
      if (state_r == ST_BUS) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end

      // Writeback to x0 still runs the bus read but never raises oRegDv
      if (state_nx_s == ST_WB) begin
        reg_dv_r   <= (rd_r != '0);
        reg_addr_r <= rd_r;
        reg_data_r <= load_extract(op_r, off_r, bus.iBusRData);
      end else begin
        reg_dv_r   <= 1'b0;
        reg_addr_r <= '0;
        reg_data_r <= '0;
      end

      if (state_nx_s == ST_ERR) begin
        exc_valid_r <= 1'b1;
        exc_code_r  <= code_nx_s;
      end else begin
        exc_valid_r <= 1'b0;
        exc_code_r  <= 2'b00;
      end
    end
  end

  assign bus.oReady    = ready_r;
  assign bus.oStall    = stall_r;
  assign bus.oBusReq   = req_r;
  assign bus.oBusWe    = we_r;
  assign bus.oBusAddr  = bus_addr_r;
  assign bus.oBusWData = bus_wdata_r;
  assign bus.oBusBe    = bus_be_r;
  assign bus.oRegDv    = reg_dv_r;
  assign bus.oRegAddr  = reg_addr_r;
  assign bus.oRegData  = reg_data_r;
  assign bus.oExcValid = exc_valid_r;
  assign bus.oExcCode  = exc_code_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed cases followed by random loads/stores, each compared against a
// transaction-level reference model (legality, lanes, extension, latency).
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if ifc ();

  mem_access_ctrl #(.cXLEN(32), .cRegSelBitW(5), .cTimeoutCyc(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Quiescent request inputs with garbage on the don't-care fields
  task automatic idle_inputs;
    ifc.iRead     = 1'b0;
    ifc.iWrite    = 1'b0;
    ifc.iBusAck   = 1'b0;
    ifc.iBusErr   = 1'b0;
    ifc.iAddr     = $urandom;
    ifc.iData     = $urandom;
    ifc.iOpType   = 3'($urandom);
    ifc.iRdAddr   = 5'($urandom);
    ifc.iBusRData = $urandom;
  endtask

  // 0 ok, 1 misaligned, 2 illegal opType
  function automatic int exp_exc(input bit is_store, input logic [2:0] op, input logic [31:0] addr);
    int size;
    if (op == 3'd3 || op >= 3'd6 || (is_store && op >= 3'd4)) return 2;
    size = 1 << op[1:0];
    if ((addr & (size - 1)) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] addr);
    int off;
    off = int'(addr & 32'd3);
    if (op[1:0] == 2'd0) return 4'(1 << off);
    if (op[1:0] == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] d);
    if (op[1:0] == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (op[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] v;
    sh = rdata >> (8 * (addr & 32'd3));
    case (op)
      3'd0: begin
        v = sh & 32'hFF;
        if (v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      3'd1: begin
        v = sh & 32'hFFFF;
        if (v >= 32'h8000) v = v + 32'hFFFF0000;
      end
      3'd4:    v = sh & 32'hFF;
      3'd5:    v = sh & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  // One complete request; delay < 0 means the bus never acknowledges
  task automatic run_txn(input bit rd_en, input bit wr_en, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] op, input logic [4:0] rd,
                         input logic [31:0] rdata, input bit err, input int delay);
    bit is_store;
    int exc;
    int cyc;
    is_store = wr_en;
    exc = exp_exc(is_store, op, addr);
    check_eq("ready_before", ifc.oReady, 32'd1);
    ifc.iRead   = rd_en;
    ifc.iWrite  = wr_en;
    ifc.iAddr   = addr;
    ifc.iData   = data;
    ifc.iOpType = op;
    ifc.iRdAddr = rd;
    tick();
    idle_inputs();
    if (exc != 0) begin
      check_eq("dec_req", ifc.oBusReq, 32'd0);
      check_eq("dec_exc_valid", ifc.oExcValid, 32'd1);
      check_eq("dec_exc_code", ifc.oExcCode, exc);
      tick();
      check_eq("dec_exc_pulse", ifc.oExcValid, 32'd0);
      check_eq("dec_ready", ifc.oReady, 32'd1);
      return;
    end
    check_eq("bus_req", ifc.oBusReq, 32'd1);
    check_eq("stall", ifc.oStall, 32'd1);
    check_eq("ready_busy", ifc.oReady, 32'd0);
    check_eq("bus_addr", ifc.oBusAddr, addr & 32'hFFFFFFFC);
    check_eq("bus_we", ifc.oBusWe, is_store);
    if (is_store || op == 3'd2) check_eq("bus_be", ifc.oBusBe, exp_be(op, addr));
    if (is_store) check_eq("bus_wdata", ifc.oBusWData, exp_wdata(op, data));
    if (delay < 0) begin
      cyc = 1;
      while (ifc.oBusReq && cyc < 400) begin
        tick();
        if (ifc.oBusReq) cyc++;
      end
      check_eq("tmo_req_cycles", cyc, TMO);
      check_eq("tmo_req_drop", ifc.oBusReq, 32'd0);
      check_eq("tmo_exc_valid", ifc.oExcValid, 32'd1);
      check_eq("tmo_exc_code", ifc.oExcCode, 32'd3);
      check_eq("tmo_no_wb", ifc.oRegDv, 32'd0);
      tick();
      check_eq("tmo_ready", ifc.oReady, 32'd1);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      tick();
      check_eq("req_hold", ifc.oBusReq, 32'd1);
      check_eq("addr_hold", ifc.oBusAddr, addr & 32'hFFFFFFFC);
    end
    ifc.iBusAck   = 1'b1;
    ifc.iBusErr   = err;
    ifc.iBusRData = rdata;
    tick();
    idle_inputs();
    check_eq("req_drop", ifc.oBusReq, 32'd0);
    if (err) begin
      check_eq("berr_exc_valid", ifc.oExcValid, 32'd1);
      check_eq("berr_exc_code", ifc.oExcCode, 32'd3);
      check_eq("berr_no_wb", ifc.oRegDv, 32'd0);
      tick();
      check_eq("berr_ready", ifc.oReady, 32'd1);
    end else if (is_store) begin
      check_eq("st_no_wb", ifc.oRegDv, 32'd0);
      check_eq("st_no_exc", ifc.oExcValid, 32'd0);
      check_eq("st_ready", ifc.oReady, 32'd1);
    end else begin
      check_eq("ld_no_exc", ifc.oExcValid, 32'd0);
      check_eq("ld_reg_dv", ifc.oRegDv, (rd != 5'd0));
      if (rd != 5'd0) begin
        check_eq("ld_reg_addr", ifc.oRegAddr, rd);
        check_eq("ld_reg_data", ifc.oRegData, exp_load(op, addr, rdata));
      end
      check_eq("ld_ready_wb", ifc.oReady, 32'd0);
      tick();
      check_eq("ld_dv_pulse", ifc.oRegDv, 32'd0);
      check_eq("ld_ready", ifc.oReady, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check_eq("rst_ready", ifc.oReady, 32'd1);
    check_eq("rst_stall", ifc.oStall, 32'd0);
    check_eq("rst_req", ifc.oBusReq, 32'd0);
    check_eq("rst_we", ifc.oBusWe, 32'd0);
    check_eq("rst_be", ifc.oBusBe, 32'd0);
    check_eq("rst_dv", ifc.oRegDv, 32'd0);
    check_eq("rst_exc", ifc.oExcValid, 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    run_txn(1, 0, 32'h104, 32'h0, 3'b010, 5'd5, 32'hDEADBEEF, 0, 0);
    run_txn(1, 0, 32'h203, 32'h0, 3'b000, 5'd7, 32'h80112233, 0, 1);
    run_txn(1, 0, 32'h203, 32'h0, 3'b100, 5'd8, 32'h80112233, 0, 0);
    run_txn(1, 0, 32'h202, 32'h0, 3'b001, 5'd9, 32'h80112233, 0, 2);
    run_txn(0, 1, 32'h22, 32'h0000ABCD, 3'b001, 5'd3, 32'h0, 0, 0);
    run_txn(1, 1, 32'h31, 32'h000000A5, 3'b000, 5'd3, 32'h0, 0, 1);
    run_txn(1, 0, 32'h101, 32'h0, 3'b010, 5'd4, 32'h0, 0, 0);
    run_txn(0, 1, 32'h100, 32'h0, 3'b100, 5'd4, 32'h0, 0, 0);
    run_txn(1, 0, 32'h103, 32'h0, 3'b111, 5'd4, 32'h0, 0, 0);
    run_txn(1, 0, 32'h40, 32'h0, 3'b010, 5'd6, 32'h0, 0, -1);
    run_txn(1, 0, 32'h44, 32'h0, 3'b010, 5'd6, 32'h12345678, 1, 1);
    run_txn(1, 0, 32'h48, 32'h0, 3'b010, 5'd0, 32'h12345678, 0, 0);

    // Reset in the middle of a bus access
    ifc.iRead   = 1'b1;
    ifc.iAddr   = 32'h300;
    ifc.iOpType = 3'b010;
    ifc.iRdAddr = 5'd10;
    tick();
    idle_inputs();
    check_eq("mid_req", ifc.oBusReq, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req", ifc.oBusReq, 32'd0);
    check_eq("mid_rst_ready", ifc.oReady, 32'd1);
    check_eq("mid_rst_stall", ifc.oStall, 32'd0);
    ifc.iBusAck   = 1'b1;
    ifc.iBusRData = 32'hCAFEF00D;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_rst_dv", ifc.oRegDv, 32'd0);
      check_eq("post_rst_exc", ifc.oExcValid, 32'd0);
      check_eq("post_rst_req", ifc.oBusReq, 32'd0);
    end
    idle_inputs();
    tick();

    // Random traffic with stray acks during idle gaps
    for (int t = 0; t < 150; t++) begin
      int          sel;
      bit          r;
      bit          w;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [4:0]  rd;
      sel = $urandom_range(0, 2);
      r = (sel != 1);
      w = (sel != 0);
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: op = 3'd0;
          1: op = 3'd1;
          2: op = 3'd2;
          3: op = w ? 3'd0 : 3'd4;
          default: op = w ? 3'd2 : 3'd5;
        endcase
      end
      addr = $urandom;
      if ($urandom_range(0, 2) == 0) addr = addr & 32'hFFFFFFFC;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_txn(r, w, addr, $urandom, op, rd, $urandom, ($urandom_range(0, 9) == 0),
              $urandom_range(0, 3));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        ifc.iBusAck = 1'($urandom);
        ifc.iBusErr = 1'($urandom);
        tick();
        check_eq("idle_req", ifc.oBusReq, 32'd0);
        check_eq("idle_dv", ifc.oRegDv, 32'd0);
        check_eq("idle_exc", ifc.oExcValid, 32'd0);
      end
      idle_inputs();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
